booth_seq_divider: RTL and testbench

//  Iterative radix-2 non-restoring divider. It is the inverse-operation companion
//  to the radix-4 Booth multiplier datapath and shares that datapath's flop style.

---
 rtl/booth_arith_pkg.sv | 21 ++
 rtl/booth_seq_divider_if.sv | 31 +++
 rtl/nr_div_step.sv | 29 ++
 rtl/booth_seq_divider.sv | 177 +++++++++++++++++
 tb/tb_booth_seq_divider.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/booth_arith_pkg.sv
// Shared arithmetic package for the Booth multiplier / sequential divider pair.
// Holds the divider FSM encoding, the default operand width and a
// two's-complement magnitude helper usable at any width up to ABS_W.
package booth_arith_pkg;

   localparam int unsigned ARITH_W = 8;
   localparam int unsigned ABS_W   = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      FIX  = 2'd2
   } div_state_e;

   // Conditional negate: callers zero-extend to ABS_W and truncate the result
   // back to their own width; the low bits are the N-bit two's-complement value.
   function automatic logic [ABS_W-1:0] abs_n(input logic [ABS_W-1:0] x, input logic sgn);
      return sgn ? (~x + ABS_W'(1)) : x;
   endfunction

endpackage

// File: rtl/booth_seq_divider_if.sv
// Request/response bundle for booth_seq_divider.
//   master: drives start, op_signed, dividend, divisor; observes results/status
//   slave : the divider side
interface booth_seq_divider_if
   import booth_arith_pkg::*;
#(
   parameter int unsigned N = ARITH_W
);

   logic         start;
   logic         op_signed;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         busy;
   logic         done;
   logic         dbz;
   logic         ovf;

   modport master (
      output start, op_signed, dividend, divisor,
      input  quotient, remainder, busy, done, dbz, ovf
   );

   modport slave (
      input  start, op_signed, dividend, divisor,
      output quotient, remainder, busy, done, dbz, ovf
   );

endinterface

// File: rtl/nr_div_step.sv
// One radix-2 non-restoring division step (combinational).
//   p        : current N+1 bit signed partial remainder
//   d        : divisor magnitude
//   bit_in   : next dividend bit shifted into the partial remainder
//   p_next_c : new partial remainder
//   q_bit_c  : quotient bit produced by this step
module nr_div_step
   import booth_arith_pkg::*;
#(
   parameter int unsigned N = ARITH_W
) (
   input  logic [N:0]   p,
   input  logic [N-1:0] d,
   input  logic         bit_in,
   output logic [N:0]   p_next_c,
   output logic         q_bit_c
);

   logic [N:0] shifted;

   // Arithmetic wraps modulo 2^(N+1); the result always lies in [-d, d) so it
   // is representable even though the shifted intermediate may not be.
   always_comb begin
      shifted  = {p[N-1:0], bit_in};
      p_next_c = p[N] ? (shifted + {1'b0, d}) : (shifted - {1'b0, d});
      q_bit_c  = ~p_next_c[N];
   end

endmodule

// File: rtl/booth_seq_divider.sv
// Iterative radix-2 non-restoring divider, signed or unsigned.
//   clk, clr_n : clock and asynchronous active-low reset
//   bus        : booth_seq_divider_if.slave
//                start/op_signed/dividend/divisor in; quotient/remainder,
//                busy, done (1-cycle pulse), dbz, ovf out (all registered)
// Results arrive N+1 clocks after an accepted start (1 clock on divide-by-zero).
module booth_seq_divider
   import booth_arith_pkg::*;
#(
   parameter int unsigned N = ARITH_W
) (
   input logic                clk,
   input logic                clr_n,
   booth_seq_divider_if.slave bus
);

   localparam int unsigned CW = $clog2(N + 1);

   div_state_e    state, state_nxt;
   logic [CW-1:0] count, count_nxt;
   logic [N:0]    p, p_nxt;          // partial remainder
   logic [N-1:0]  a, a_nxt;          // dividend magnitude, becomes quotient magnitude
   logic [N-1:0]  d, d_nxt;          // divisor magnitude
   logic          neg_q, neg_q_nxt;
   logic          neg_r, neg_r_nxt;
   logic          dbz_p, dbz_p_nxt;  // pending divide-by-zero
   logic          ovf_p, ovf_p_nxt;  // pending signed overflow

   logic [N-1:0]  quotient_r, quotient_nxt;
   logic [N-1:0]  remainder_r, remainder_nxt;
   logic          busy_r, busy_nxt;
   logic          done_r, done_nxt;
   logic          dbz_r, dbz_nxt;
   logic          ovf_r, ovf_nxt;

   logic          sgn_a_c, sgn_b_c, zero_div_c, ovf_case_c;
   logic [N-1:0]  a_mag_c, d_mag_c, rem_mag_c, q_fix_c, r_fix_c;
   logic [N:0]    step_p_c;
   logic          step_q_c;

   // Operand decode for the start cycle
   assign sgn_a_c    = bus.op_signed & bus.dividend[N-1];
   assign sgn_b_c    = bus.op_signed & bus.divisor[N-1];
   assign zero_div_c = (bus.divisor == '0);
   assign ovf_case_c = bus.op_signed & (bus.dividend == {1'b1, {(N-1){1'b0}}})
                       & (bus.divisor == '1);
   assign a_mag_c    = N'(abs_n(ABS_W'(bus.dividend), sgn_a_c));
   assign d_mag_c    = N'(abs_n(ABS_W'(bus.divisor), sgn_b_c));

   // Final correction and sign application
   assign rem_mag_c  = p[N] ? (p[N-1:0] + d) : p[N-1:0];
   assign q_fix_c    = N'(abs_n(ABS_W'(a), neg_q));
   assign r_fix_c    = N'(abs_n(ABS_W'(rem_mag_c), neg_r));

   nr_div_step #(.N(N)) u_step (
      .p        (p),
      .d        (d),
      .bit_in   (a[N-1]),
      .p_next_c (step_p_c),
      .q_bit_c  (step_q_c)
   );

   // State and datapath registers
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state       <= IDLE;
         count       <= '0;
         p           <= '0;
         a           <= '0;
         d           <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         dbz_p       <= 1'b0;
         ovf_p       <= 1'b0;
         quotient_r  <= '0;
         remainder_r <= '0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         dbz_r       <= 1'b0;
         ovf_r       <= 1'b0;
      end else begin
         state       <= state_nxt;
         count       <= count_nxt;
         p           <= p_nxt;
         a           <= a_nxt;
         d           <= d_nxt;
         neg_q       <= neg_q_nxt;
         neg_r       <= neg_r_nxt;
         dbz_p       <= dbz_p_nxt;
         ovf_p       <= ovf_p_nxt;
         quotient_r  <= quotient_nxt;
         remainder_r <= remainder_nxt;
         busy_r      <= busy_nxt;
         done_r      <= done_nxt;
         dbz_r       <= dbz_nxt;
         ovf_r       <= ovf_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt     = state;
      count_nxt     = count;
      p_nxt         = p;
      a_nxt         = a;
      d_nxt         = d;
      neg_q_nxt     = neg_q;
      neg_r_nxt     = neg_r;
      dbz_p_nxt     = dbz_p;
      ovf_p_nxt     = ovf_p;
      quotient_nxt  = quotient_r;
      remainder_nxt = remainder_r;
      busy_nxt      = busy_r;
      done_nxt      = 1'b0;
      dbz_nxt       = dbz_r;
      ovf_nxt       = ovf_r;

      case (state)
         IDLE: begin
            if (bus.start) begin
               count_nxt = '0;
               p_nxt     = '0;
               // Divide-by-zero returns the dividend untouched, so keep it raw
               a_nxt     = zero_div_c ? bus.dividend : a_mag_c;
               d_nxt     = d_mag_c;
               neg_q_nxt = sgn_a_c ^ sgn_b_c;
               neg_r_nxt = sgn_a_c;
               dbz_p_nxt = zero_div_c;
               ovf_p_nxt = ovf_case_c;
               busy_nxt  = 1'b1;
               dbz_nxt   = 1'b0;
               ovf_nxt   = 1'b0;
               state_nxt = zero_div_c ? FIX : ITER;
            end
         end

         ITER: begin
            p_nxt     = step_p_c;
            a_nxt     = {a[N-2:0], step_q_c};
            count_nxt = count + CW'(1);
            if (count == CW'(N - 1)) begin
               state_nxt = FIX;
            end
         end

         FIX: begin
            if (dbz_p) begin
               quotient_nxt  = '1;
               remainder_nxt = a;
               dbz_nxt       = 1'b1;
               ovf_nxt       = 1'b0;
            end else begin
               quotient_nxt  = q_fix_c;
               remainder_nxt = r_fix_c;
               dbz_nxt       = 1'b0;
               ovf_nxt       = ovf_p;
            end
            done_nxt  = 1'b1;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   assign bus.quotient  = quotient_r;
   assign bus.remainder = remainder_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.dbz       = dbz_r;
   assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_booth_seq_divider.sv
// Directed self-checking bench for booth_seq_divider (N = 8).
module tb_booth_seq_divider;

   localparam int unsigned N = 8;

   logic clk;
   logic clr_n;
   int   checks;
   int   errors;
   int   n;
   int   done_seen;

   booth_seq_divider_if #(.N(N)) bus ();

   booth_seq_divider #(.N(N)) dut (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one request for exactly one sampling edge
   task automatic do_start(input logic sgn, input logic [N-1:0] x, input logic [N-1:0] y);
      bus.start     = 1'b1;
      bus.op_signed = sgn;
      bus.dividend  = x;
      bus.divisor   = y;
      step();
      bus.start     = 1'b0;
   endtask

   // Clocks until done is seen or the budget expires; returns clocks taken
   task automatic wait_done(input string tag, output int cnt);
      cnt = 0;
      do begin
         step();
         cnt++;
      end while (!bus.done && cnt < 20);
      check({tag, "_done_seen"}, 32'(bus.done), 32'd1);
   endtask

   task automatic check_result(input string tag, input logic [N-1:0] q, input logic [N-1:0] r,
                               input logic z, input logic o);
      check({tag, "_q"},   32'(bus.quotient),  32'(q));
      check({tag, "_r"},   32'(bus.remainder), 32'(r));
      check({tag, "_dbz"}, 32'(bus.dbz),       32'(z));
      check({tag, "_ovf"}, 32'(bus.ovf),       32'(o));
      check({tag, "_busy"}, 32'(bus.busy),     32'd0);
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      clr_n         = 1'b0;
      bus.start     = 1'b0;
      bus.op_signed = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;
      step();
      step();
      clr_n = 1'b1;
      step();

      // Reset state
      check("rst_q",    32'(bus.quotient),  32'd0);
      check("rst_r",    32'(bus.remainder), 32'd0);
      check("rst_busy", 32'(bus.busy),      32'd0);
      check("rst_done", 32'(bus.done),      32'd0);
      check("rst_dbz",  32'(bus.dbz),       32'd0);
      check("rst_ovf",  32'(bus.ovf),       32'd0);

      // Unsigned 100/7
      do_start(1'b0, 8'h64, 8'h07);
      check("u100_busy_rise", 32'(bus.busy), 32'd1);
      wait_done("u100", n);
      check("u100_latency", 32'(n), 32'd9);
      check_result("u100", 8'h0E, 8'h02, 1'b0, 1'b0);
      step();
      check("u100_done_pulse", 32'(bus.done), 32'd0);
      check("u100_hold_q", 32'(bus.quotient), 32'h0E);

      // Signed -100/7 and 100/-7
      do_start(1'b1, 8'h9C, 8'h07);
      wait_done("sneg_a", n);
      check("sneg_a_latency", 32'(n), 32'd9);
      check_result("sneg_a", 8'hF2, 8'hFE, 1'b0, 1'b0);
      do_start(1'b1, 8'h64, 8'hF9);
      wait_done("sneg_b", n);
      check_result("sneg_b", 8'hF2, 8'h02, 1'b0, 1'b0);

      // Divide by zero in both modes, then recovery
      do_start(1'b0, 8'h37, 8'h00);
      wait_done("dbz_u", n);
      check("dbz_u_latency", 32'(n), 32'd1);
      check_result("dbz_u", 8'hFF, 8'h37, 1'b1, 1'b0);
      do_start(1'b1, 8'h37, 8'h00);
      wait_done("dbz_s", n);
      check("dbz_s_latency", 32'(n), 32'd1);
      check_result("dbz_s", 8'hFF, 8'h37, 1'b1, 1'b0);
      do_start(1'b0, 8'h09, 8'h03);
      check("dbz_clear_on_start", 32'(bus.dbz), 32'd0);
      wait_done("u9_3", n);
      check_result("u9_3", 8'h03, 8'h00, 1'b0, 1'b0);

      // Signed overflow and its unsigned counterpart
      do_start(1'b1, 8'h80, 8'hFF);
      wait_done("sovf", n);
      check("sovf_latency", 32'(n), 32'd9);
      check_result("sovf", 8'h80, 8'h00, 1'b0, 1'b1);
      do_start(1'b0, 8'h80, 8'hFF);
      check("ovf_clear_on_start", 32'(bus.ovf), 32'd0);
      wait_done("u80_ff", n);
      check_result("u80_ff", 8'h00, 8'h80, 1'b0, 1'b0);

      // Start re-pulsed mid-operation is ignored
      do_start(1'b0, 8'h64, 8'h07);
      step();
      step();
      bus.start     = 1'b1;
      bus.op_signed = 1'b0;
      bus.dividend  = 8'hC8;
      bus.divisor   = 8'h03;
      step();
      bus.start     = 1'b0;
      wait_done("ign", n);
      check("ign_latency", 32'(n + 3), 32'd9);
      check_result("ign", 8'h0E, 8'h02, 1'b0, 1'b0);

      // Back-to-back: start accepted during the done cycle
      do_start(1'b0, 8'hC8, 8'h03);
      check("b2b_busy", 32'(bus.busy), 32'd1);
      wait_done("b2b", n);
      check("b2b_latency", 32'(n), 32'd9);
      check_result("b2b", 8'h42, 8'h02, 1'b0, 1'b0);

      // Reset mid-operation aborts without a done pulse
      do_start(1'b0, 8'h64, 8'h07);
      step();
      step();
      step();
      clr_n = 1'b0;
      #1;
      check("abort_busy", 32'(bus.busy),      32'd0);
      check("abort_q",    32'(bus.quotient),  32'd0);
      check("abort_r",    32'(bus.remainder), 32'd0);
      @(posedge clk);
      #1;
      clr_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus.done) done_seen++;
      end
      check("abort_no_done", 32'(done_seen), 32'd0);
      check("abort_idle",    32'(bus.busy),  32'd0);

      // Operation after abort completes normally
      do_start(1'b1, 8'h9C, 8'h07);
      wait_done("post", n);
      check("post_latency", 32'(n), 32'd9);
      check_result("post", 8'hF2, 8'hFE, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
